// File: rtl/adc_pkg.sv
// Shared widths and types for the ADC capture path.
// The sequencer takes its default geometry from here.
package adc_pkg;

    localparam int ADC_SLICE_W  = 216;
    localparam int ADC_N_SLICES = 4;
    localparam int ADC_WORD_W   = ADC_SLICE_W * ADC_N_SLICES;

    typedef logic [ADC_WORD_W-1:0]   adc_word_t;
    typedef logic [ADC_SLICE_W-1:0]  adc_slice_t;
    typedef logic [ADC_N_SLICES-1:0] adc_mask_t;

endpackage

// File: rtl/adc_lowest_bit_sel.sv
// Combinational lowest-set-bit selector.
// Returns the index, a one-hot mask to clear that bit, and whether it is the only bit set.
module adc_lowest_bit_sel #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     mask_i,
    output logic [IDX_W-1:0] idx_o,
    output logic [N-1:0]     clr_o,
    output logic             single_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

    assign clr_o    = mask_i & (~mask_i + N'(1));
    assign single_o = (mask_i != '0) && ((mask_i & (mask_i - N'(1))) == '0);

endmodule

// File: rtl/adc_slice_sequencer.sv
// Serialises the enabled channel slices of each ADC capture word onto a single
// valid/ready stream, lowest channel first, with one ACTIVE and one PENDING slot.
module adc_slice_sequencer
    import adc_pkg::*;
#(
    parameter int SLICE_W  = ADC_SLICE_W,
    parameter int N_SLICES = ADC_N_SLICES,
    parameter int CNT_W    = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        in_valid,
    input  logic [N_SLICES*SLICE_W-1:0] in_data,
    input  logic [N_SLICES-1:0]         ch_en,
    output logic [SLICE_W-1:0]          m_data,
    output logic [1:0]                  m_chan,
    output logic                        m_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    input  logic                        clr_ovf,
    output logic                        ovf_flag,
    output logic [CNT_W-1:0]            drop_cnt
);

    localparam int WORD_W = N_SLICES * SLICE_W;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [N_SLICES-1:0] act_rem_q,   act_rem_d;
    logic [WORD_W-1:0]   act_data_q,  act_data_d;
    logic [N_SLICES-1:0] pend_mask_q, pend_mask_d;
    logic [WORD_W-1:0]   pend_data_q, pend_data_d;
    logic                ovf_q,       ovf_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;

    logic [1:0]          sel_idx;
    logic [N_SLICES-1:0] sel_clr;
    logic                sel_single;

    logic xfer, act_free, pend_full, pend_move;
    logic in_acc, to_act, to_pend, drop;

    adc_lowest_bit_sel #(
        .N     (N_SLICES),
        .IDX_W (2)
    ) u_sel (
        .mask_i   (act_rem_q),
        .idx_o    (sel_idx),
        .clr_o    (sel_clr),
        .single_o (sel_single)
    );

    // Output view of the ACTIVE slot; data is forced to zero while idle.
    assign m_valid  = |act_rem_q;
    assign m_chan   = sel_idx;
    assign m_last   = sel_single;
    assign m_data   = m_valid ? act_data_q[int'(sel_idx)*SLICE_W +: SLICE_W] : '0;
    assign ovf_flag = ovf_q;
    assign drop_cnt = cnt_q;

    assign xfer      = m_valid & m_ready;
    assign act_free  = ~m_valid | (xfer & sel_single);
    assign pend_full = |pend_mask_q;
    assign pend_move = pend_full & act_free;

    // A word with no enabled channel is discarded without counting as a drop.
    assign in_acc  = in_valid & (|ch_en);
    assign to_act  = in_acc & act_free & ~pend_full;
    assign to_pend = in_acc & ~to_act & (~pend_full | pend_move);
    assign drop    = in_acc & ~to_act & ~to_pend;

    always_comb begin
        act_rem_d   = act_rem_q;
        act_data_d  = act_data_q;
        pend_mask_d = pend_mask_q;
        pend_data_d = pend_data_q;

        if (xfer) begin
            act_rem_d = act_rem_q & ~sel_clr;
        end

        if (pend_move) begin
            act_rem_d   = pend_mask_q;
            act_data_d  = pend_data_q;
            pend_mask_d = '0;
        end else if (to_act) begin
            act_rem_d  = ch_en;
            act_data_d = in_data;
        end

        if (to_pend) begin
            pend_mask_d = ch_en;
            pend_data_d = in_data;
        end
    end

    // Clear wins over a drop landing in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        cnt_d = cnt_q;
        if (clr_ovf) begin
            ovf_d = 1'b0;
            cnt_d = '0;
        end else if (drop) begin
            ovf_d = 1'b1;
            cnt_d = sat_inc(cnt_q);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            act_rem_q   <= '0;
            pend_mask_q <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            act_rem_q   <= act_rem_d;
            pend_mask_q <= pend_mask_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
        end
    end

    // Word storage is qualified by the masks, so it needs no reset.
    always_ff @(posedge aclk) begin
        act_data_q  <= act_data_d;
        pend_data_q <= pend_data_d;
    end

endmodule

// File: tb/tb_adc_slice_sequencer.sv
// Directed and randomized bench for adc_slice_sequencer against a queue-based reference model.
module tb_adc_slice_sequencer;

    localparam int SW = 216;
    localparam int NS = 4;
    localparam int WW = SW * NS;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          in_valid;
    logic [WW-1:0] in_data;
    logic [NS-1:0] ch_en;
    logic [SW-1:0] m_data;
    logic [1:0]    m_chan;
    logic          m_last;
    logic          m_valid;
    logic          m_ready;
    logic          clr_ovf;
    logic          ovf_flag;
    logic [CW-1:0] drop_cnt;

    always #5 aclk = ~aclk;

    adc_slice_sequencer #(
        .SLICE_W  (SW),
        .N_SLICES (NS),
        .CNT_W    (CW)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .in_valid (in_valid),
        .in_data  (in_data),
        .ch_en    (ch_en),
        .m_data   (m_data),
        .m_chan   (m_chan),
        .m_last   (m_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .clr_ovf  (clr_ovf),
        .ovf_flag (ovf_flag),
        .drop_cnt (drop_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: channels still to send for the active word, one buffered word.
    int            act_q[$];
    logic [WW-1:0] act_w;
    logic          pend_v;
    logic [WW-1:0] pend_w;
    logic [NS-1:0] pend_m;
    logic          exp_ovf;
    int            exp_cnt;

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] r;
        for (int i = 0; i < WW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [WW-1:0] ramp_word();
        logic [WW-1:0] r;
        for (int k = 0; k < NS; k++) r[k*SW +: SW] = SW'(k + 1);
        return r;
    endfunction

    function automatic void load_act(input logic [WW-1:0] w, input logic [NS-1:0] m);
        act_q.delete();
        for (int c = 0; c < NS; c++) if (m[c]) act_q.push_back(c);
        act_w = w;
    endfunction

    function automatic void model_reset();
        act_q.delete();
        act_w   = '0;
        pend_v  = 1'b0;
        pend_w  = '0;
        pend_m  = '0;
        exp_ovf = 1'b0;
        exp_cnt = 0;
    endfunction

    function automatic void model_step(input logic iv, input logic [WW-1:0] w,
                                       input logic [NS-1:0] en, input logic rdy,
                                       input logic clr);
        logic dropped;
        dropped = 1'b0;
        if (rdy && act_q.size() != 0) void'(act_q.pop_front());
        if (pend_v && act_q.size() == 0) begin
            load_act(pend_w, pend_m);
            pend_v = 1'b0;
        end
        if (iv && en != '0) begin
            if (act_q.size() == 0) load_act(w, en);
            else if (!pend_v) begin
                pend_v = 1'b1;
                pend_w = w;
                pend_m = en;
            end else dropped = 1'b1;
        end
        if (clr) begin
            exp_ovf = 1'b0;
            exp_cnt = 0;
        end else if (dropped) begin
            exp_ovf = 1'b1;
            if (exp_cnt < CNT_MAX) exp_cnt++;
        end
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("m_valid", 256'(m_valid), 256'(act_q.size() != 0));
        if (act_q.size() != 0) begin
            chk("m_chan", 256'(m_chan), 256'(act_q[0]));
            chk("m_data", 256'(m_data), 256'(act_w[act_q[0]*SW +: SW]));
            chk("m_last", 256'(m_last), 256'(act_q.size() == 1));
        end
        chk("ovf_flag", 256'(ovf_flag), 256'(exp_ovf));
        chk("drop_cnt", 256'(drop_cnt), 256'(exp_cnt));
    endtask

    task automatic step(input logic iv, input logic [WW-1:0] w, input logic [NS-1:0] en,
                        input logic rdy, input logic clr);
        in_valid = iv;
        in_data  = w;
        ch_en    = en;
        m_ready  = rdy;
        clr_ovf  = clr;
        @(posedge aclk);
        model_step(iv, w, en, rdy, clr);
        #1;
        check_all();
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, rdy, 1'b0);
    endtask

    initial begin
        logic [WW-1:0] w;
        aresetn  = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        ch_en    = '0;
        m_ready  = 1'b0;
        clr_ovf  = 1'b0;
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_m_valid", 256'(m_valid), 256'(0));
        chk("rst_m_data", 256'(m_data), 256'(0));
        chk("rst_m_chan", 256'(m_chan), 256'(0));
        chk("rst_m_last", 256'(m_last), 256'(0));
        chk("rst_ovf", 256'(ovf_flag), 256'(0));
        chk("rst_cnt", 256'(drop_cnt), 256'(0));
        aresetn = 1'b1;
        idle(1'b1, 2);

        // Basic serialisation: one-clock latency, four beats
        step(1'b1, ramp_word(), 4'hF, 1'b1, 1'b0);
        chk("basic_first_chan", 256'(m_chan), 256'(0));
        chk("basic_first_data", 256'(m_data), 256'(1));
        idle(1'b1, 5);

        // Sparse mask, then an all-disabled word
        step(1'b1, ramp_word(), 4'b1010, 1'b1, 1'b0);
        chk("sparse_first_chan", 256'(m_chan), 256'(1));
        idle(1'b1, 3);
        step(1'b1, rand_word(), 4'h0, 1'b1, 1'b0);
        chk("zero_mask_no_valid", 256'(m_valid), 256'(0));
        idle(1'b1, 2);

        // Stall: A active, B pending, C dropped; hold then drain
        step(1'b1, rand_word(), 4'hF, 1'b0, 1'b0);
        step(1'b1, rand_word(), 4'hF, 1'b0, 1'b0);
        step(1'b1, rand_word(), 4'hF, 1'b0, 1'b0);
        chk("stall_drop_cnt", 256'(drop_cnt), 256'(1));
        idle(1'b0, 3);
        idle(1'b1, 10);
        step(1'b0, '0, '0, 1'b1, 1'b1);

        // Seamless handoff on A's last beat with PENDING full
        step(1'b1, rand_word(), 4'hF, 1'b0, 1'b0);
        step(1'b1, rand_word(), 4'hF, 1'b0, 1'b0);
        idle(1'b1, 3);
        step(1'b1, rand_word(), 4'hF, 1'b1, 1'b0);
        chk("handoff_no_drop", 256'(ovf_flag), 256'(0));
        idle(1'b1, 10);

        // Saturation and clear-vs-drop priority
        step(1'b1, rand_word(), 4'hF, 1'b0, 1'b0);
        step(1'b1, rand_word(), 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, rand_word(), 4'hF, 1'b0, 1'b0);
        chk("sat_cnt", 256'(drop_cnt), 256'(CNT_MAX));
        step(1'b1, rand_word(), 4'hF, 1'b0, 1'b1);
        chk("clr_with_drop_flag", 256'(ovf_flag), 256'(0));
        chk("clr_with_drop_cnt", 256'(drop_cnt), 256'(0));
        idle(1'b1, 10);

        // Mid-stream asynchronous reset
        step(1'b1, rand_word(), 4'hF, 1'b1, 1'b0);
        idle(1'b1, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("async_rst_valid", 256'(m_valid), 256'(0));
        model_reset();
        in_valid = 1'b0;
        @(posedge aclk);
        #1;
        check_all();
        aresetn = 1'b1;
        idle(1'b1, 2);
        step(1'b1, ramp_word(), 4'hF, 1'b1, 1'b0);
        chk("post_rst_chan0", 256'(m_chan), 256'(0));
        idle(1'b1, 4);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            w = rand_word();
            step(($urandom_range(0, 3) == 0), w, 4'($urandom), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 31) == 0));
        end
        idle(1'b1, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
